// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
package alu_seq_pkg;

    localparam int unsigned DEF_CTL_WIDTH = 5;

    // Register fields sit directly below the opcode, in this order.
    localparam int unsigned RA_FIELD_IDX = 1;
    localparam int unsigned RB_FIELD_IDX = 2;
    localparam int unsigned RC_FIELD_IDX = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_DONE = 3'd7
    } seq_state_e;

    // Single-bit datapath strobes driven by the sequencer.
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
    } strobe_t;

    // LSB position of register field idx inside an instruction word.
    function automatic int unsigned field_lsb(input int unsigned dw, input int unsigned cw,
                                              input int unsigned rw, input int unsigned idx);
        return dw - cw - idx * rw;
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Registered decoder: register field plus enable to a one-hot register select.
module reg_sel_decoder #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SEL_WIDTH-1:0] sel_i,
    input  logic                 en_i,
    output logic [NUM_REGS-1:0]  onehot_o
);

    logic [NUM_REGS-1:0] onehot_d;
    logic [NUM_REGS-1:0] onehot_q;

    // Decode the selected register; all zeros when disabled.
    always_comb begin
        onehot_d = '0;
        if (en_i) begin
            onehot_d = NUM_REGS'(1) << sel_i;
        end
    end

    // Select register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign onehot_o = onehot_q;

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer for a single-bus ALU datapath.
// Optional build macro ALU_SEQ_MEM_WAIT_EN: T1 holds until Mem_Ready.
// Without it T1 is always one cycle and Mem_Ready is ignored.
// All outputs are registered from the next state so they line up with the state.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned NUM_ALU_OPS = 16,
    parameter int unsigned CTL_WIDTH   = DEF_CTL_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  Mem_Ready,
    input  logic [DATA_WIDTH-1:0] IR,
    output logic                  PC_Out,
    output logic                  MAR_In,
    output logic                  IncPC,
    output logic                  Z_In,
    output logic                  ZLO_Out,
    output logic                  PC_In,
    output logic                  Read,
    output logic                  MDR_In,
    output logic                  MDR_Out,
    output logic                  IR_In,
    output logic                  Y_In,
    output logic [NUM_REGS-1:0]   R_Out,
    output logic [NUM_REGS-1:0]   R_In,
    output logic [CTL_WIDTH-1:0]  CONTROL,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int unsigned RW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned OP_LSB = DATA_WIDTH - CTL_WIDTH;
    localparam int unsigned RA_LSB = field_lsb(DATA_WIDTH, CTL_WIDTH, RW, RA_FIELD_IDX);
    localparam int unsigned RB_LSB = field_lsb(DATA_WIDTH, CTL_WIDTH, RW, RB_FIELD_IDX);
    localparam int unsigned RC_LSB = field_lsb(DATA_WIDTH, CTL_WIDTH, RW, RC_FIELD_IDX);

    seq_state_e           state_d, state_q;
    logic [CTL_WIDTH-1:0] op_d, op_q;
    logic [RW-1:0]        ra_d, ra_q, rb_d, rb_q, rc_d, rc_q;
    logic                 err_d, err_q;
    strobe_t              st_d, st_q;
    logic [CTL_WIDTH-1:0] control_d, control_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;
    logic                 rout_en_d, rin_en_d;
    logic [RW-1:0]        rout_sel_d, rin_sel_d;
    logic                 illegal_d;
    logic                 unused_inputs;

    // Lower IR bits are not decoded; Mem_Ready is unused without the wait option.
    assign unused_inputs = ^{IR, Mem_Ready};

    // Next-state, field latch and Moore output decode of the upcoming state.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        err_d      = err_q;
        st_d       = '0;
        control_d  = '0;
        done_d     = 1'b0;
        rout_en_d  = 1'b0;
        rout_sel_d = '0;
        rin_en_d   = 1'b0;
        rin_sel_d  = '0;

        // Fields are captured on the edge that enters T3.
        if (state_q == ST_T2) begin
            op_d = IR[OP_LSB +: CTL_WIDTH];
            ra_d = IR[RA_LSB +: RW];
            rb_d = IR[RB_LSB +: RW];
            rc_d = IR[RC_LSB +: RW];
        end
        illegal_d = (32'(op_d) >= NUM_ALU_OPS);

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_T0;
                    err_d   = 1'b0;
                end
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
`ifdef ALU_SEQ_MEM_WAIT_EN
                if (Mem_Ready) begin
                    state_d = ST_T2;
                end
`else
                state_d = ST_T2;
`endif
            end
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (illegal_d) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_T0: begin
                st_d.pc_out = 1'b1;
                st_d.mar_in = 1'b1;
                st_d.inc_pc = 1'b1;
                st_d.z_in   = 1'b1;
            end
            ST_T1: begin
                st_d.read   = 1'b1;
                st_d.mdr_in = 1'b1;
                // PC update only on the first T1 cycle.
                if (state_q == ST_T0) begin
                    st_d.zlo_out = 1'b1;
                    st_d.pc_in   = 1'b1;
                end
            end
            ST_T2: begin
                st_d.mdr_out = 1'b1;
                st_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (!illegal_d) begin
                    rout_en_d  = 1'b1;
                    rout_sel_d = rb_d;
                    st_d.y_in  = 1'b1;
                end
            end
            ST_T4: begin
                rout_en_d  = 1'b1;
                rout_sel_d = rc_d;
                control_d  = op_d;
                st_d.z_in  = 1'b1;
            end
            ST_T5: begin
                st_d.zlo_out = 1'b1;
                rin_en_d     = 1'b1;
                rin_sel_d    = ra_d;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, latched fields and registered outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            err_q     <= 1'b0;
            st_q      <= '0;
            control_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            err_q     <= err_d;
            st_q      <= st_d;
            control_q <= control_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    reg_sel_decoder #(
        .NUM_REGS  (NUM_REGS),
        .SEL_WIDTH (RW)
    ) u_rout_dec (
        .clk_i    (Clock),
        .rst_ni   (Clear),
        .sel_i    (rout_sel_d),
        .en_i     (rout_en_d),
        .onehot_o (R_Out)
    );

    reg_sel_decoder #(
        .NUM_REGS  (NUM_REGS),
        .SEL_WIDTH (RW)
    ) u_rin_dec (
        .clk_i    (Clock),
        .rst_ni   (Clear),
        .sel_i    (rin_sel_d),
        .en_i     (rin_en_d),
        .onehot_o (R_In)
    );

    assign PC_Out  = st_q.pc_out;
    assign MAR_In  = st_q.mar_in;
    assign IncPC   = st_q.inc_pc;
    assign Z_In    = st_q.z_in;
    assign ZLO_Out = st_q.zlo_out;
    assign PC_In   = st_q.pc_in;
    assign Read    = st_q.read;
    assign MDR_In  = st_q.mdr_in;
    assign MDR_Out = st_q.mdr_out;
    assign IR_In   = st_q.ir_in;
    assign Y_In    = st_q.y_in;
    assign CONTROL = control_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Error   = err_q;

endmodule
